cv32e40s_rvfi_obi_tracker: RTL and testbench

CV32E40S_RVFI_OBI_TRACKER -- requirements
Module: cv32e40s_rvfi_obi_tracker

---
 rtl/cv32e40s_rvfi_pkg.sv | 27 ++
 rtl/cv32e40s_ff_one.sv | 24 ++
 rtl/cv32e40s_rvfi_obi_tracker.sv | 187 ++++++++++++++++++
 tb/tb_cv32e40s_rvfi_obi_tracker.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_rvfi_pkg.sv
// RVFI OBI tracker shared types.
// Entry state enum and per-entry control bundle.
package cv32e40s_rvfi_pkg;

    typedef enum logic [1:0] {
        RVFI_OBI_EMPTY     = 2'd0,
        RVFI_OBI_WAIT_RESP = 2'd1,
        RVFI_OBI_DONE      = 2'd2
    } rvfi_obi_state_e;

    // Address and data live in separate arrays so the
    // struct stays independent of the width parameters.
    typedef struct packed {
        rvfi_obi_state_e state;
        logic [2:0]      prot;
        logic            err;
        logic            pmp_err;
    } rvfi_obi_entry_t;

    localparam rvfi_obi_entry_t RVFI_OBI_ENTRY_RST = '{
        state:   RVFI_OBI_EMPTY,
        prot:    3'b000,
        err:     1'b0,
        pmp_err: 1'b0
    };

endpackage

// File: rtl/cv32e40s_ff_one.sv
// Find-first-one: index of the lowest set bit of in_i.
// Ports: in_i vector, first_one_o index, no_ones_o flag.
module cv32e40s_ff_one #(
    parameter int LEN = 2,
    parameter int W   = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic [LEN-1:0] in_i,
    output logic [W-1:0]   first_one_o,
    output logic           no_ones_o
);

    always_comb begin
        first_one_o = '0;
        no_ones_o   = 1'b1;
        // Scan downwards so the lowest set bit is written last.
        for (int i = LEN - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                first_one_o = W'(i);
                no_ones_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cv32e40s_rvfi_obi_tracker.sv
// In-order tracker pairing OBI requests with responses for RVFI.
// Ports: req_*/resp_* bus side, flush_i, out_* retire handshake, status.
module cv32e40s_rvfi_obi_tracker
    import cv32e40s_rvfi_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2:0]            req_prot_i,
    input  logic                  req_pmp_err_i,
    input  logic                  resp_valid_i,
    input  logic [DATA_WIDTH-1:0] resp_rdata_i,
    input  logic                  resp_err_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [2:0]            out_prot_o,
    output logic [DATA_WIDTH-1:0] out_rdata_o,
    output logic                  out_err_o,
    output logic                  out_pmp_err_o,
    output logic                  full_o,
    output logic [CW-1:0]         outstanding_o,
    output logic                  protocol_err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rvfi_obi_entry_t       r_ent   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_drop;
    logic                  r_perr;

    logic [CW-1:0]    w_valid_cnt;
    logic [CW-1:0]    w_wait_cnt;
    logic [CW-1:0]    w_occ;
    logic [DEPTH-1:0] w_wait_vec;
    logic [DEPTH-1:0] w_rot_vec;
    logic [PW-1:0]    w_first;
    logic             w_no_wait;
    logic [PW-1:0]    w_target;
    logic             w_full;
    logic             w_pop;
    logic             w_resp_drop;
    logic             w_resp_hit;
    logic             w_resp_bad;
    logic [CW:0]      w_flush_drop;
    logic             w_room;
    logic             w_alloc;
    logic             w_overflow;
    logic [PW-1:0]    w_alloc_idx;
    logic [PW-1:0]    w_tail_nxt;

    // (p + k) mod DEPTH for p, k < DEPTH; works for any DEPTH.
    function automatic logic [PW-1:0] f_wrap_add(
        input logic [PW-1:0] p,
        input logic [PW-1:0] k
    );
        logic [PW:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= (PW+1)'(DEPTH)) begin
            s = s - (PW+1)'(DEPTH);
        end
        return s[PW-1:0];
    endfunction

    always_comb begin
        w_valid_cnt = '0;
        w_wait_cnt  = '0;
        w_wait_vec  = '0;
        w_rot_vec   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wait_vec[i] = (r_ent[i].state == RVFI_OBI_WAIT_RESP);
            w_valid_cnt   = w_valid_cnt
                          + CW'(r_ent[i].state != RVFI_OBI_EMPTY);
            w_wait_cnt    = w_wait_cnt + CW'(w_wait_vec[i]);
        end
        // Rotate so bit 0 is the head: the first set bit is the oldest.
        for (int i = 0; i < DEPTH; i++) begin
            w_rot_vec[i] = w_wait_vec[f_wrap_add(r_head, PW'(i))];
        end
    end

    cv32e40s_ff_one #(
        .LEN (DEPTH),
        .W   (PW)
    ) u_ff_one (
        .in_i        (w_rot_vec),
        .first_one_o (w_first),
        .no_ones_o   (w_no_wait)
    );

    assign w_target = f_wrap_add(r_head, w_first);
    assign w_occ    = w_valid_cnt + r_drop;
    assign w_full   = (w_occ == CW'(DEPTH));

    assign out_valid_o = (r_ent[r_head].state == RVFI_OBI_DONE);
    assign w_pop       = out_valid_o && out_ready_i && !flush_i;

    assign w_resp_drop = resp_valid_i && (r_drop != '0);
    assign w_resp_hit  = resp_valid_i && (r_drop == '0) && !w_no_wait;
    assign w_resp_bad  = resp_valid_i && (r_drop == '0) && w_no_wait;

    // A legal response in the flush cycle belongs either to an
    // already-dropped request or to the oldest flushed WAIT entry.
    assign w_flush_drop = {1'b0, r_drop} + {1'b0, w_wait_cnt}
                        - (CW+1)'(resp_valid_i && !w_resp_bad);

    // In the flush cycle only the surviving drop credits take room.
    assign w_room      = flush_i ? (w_flush_drop < (CW+1)'(DEPTH))
                                 : !w_full;
    assign w_alloc     = req_valid_i && w_room;
    assign w_overflow  = req_valid_i && !w_room;
    assign w_alloc_idx = flush_i ? '0 : r_tail;
    assign w_tail_nxt  = f_wrap_add(w_alloc_idx, PW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i]   <= RVFI_OBI_ENTRY_RST;
                r_addr[i]  <= '0;
                r_rdata[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_drop <= '0;
            r_perr <= 1'b0;
        end else begin
            if (w_overflow || w_resp_bad) begin
                r_perr <= 1'b1;
            end
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_ent[i].state <= RVFI_OBI_EMPTY;
                end
                r_head <= '0;
                r_tail <= '0;
                r_drop <= w_flush_drop[CW-1:0];
            end else begin
                if (w_resp_drop) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_pop) begin
                    r_ent[r_head].state <= RVFI_OBI_EMPTY;
                    r_head <= f_wrap_add(r_head, PW'(1));
                end
                if (w_resp_hit) begin
                    r_ent[w_target].state <= RVFI_OBI_DONE;
                    r_ent[w_target].err   <= resp_err_i;
                    r_rdata[w_target]     <= resp_rdata_i;
                end
            end
            // Allocation comes last so it overrides the flush clear.
            if (w_alloc) begin
                r_ent[w_alloc_idx].state   <= req_pmp_err_i
                                            ? RVFI_OBI_DONE
                                            : RVFI_OBI_WAIT_RESP;
                r_ent[w_alloc_idx].prot    <= req_prot_i;
                r_ent[w_alloc_idx].err     <= 1'b0;
                r_ent[w_alloc_idx].pmp_err <= req_pmp_err_i;
                r_addr[w_alloc_idx]        <= req_addr_i;
                r_rdata[w_alloc_idx]       <= '0;
                r_tail                     <= w_tail_nxt;
            end
        end
    end

    // Payload is zero unless a retirement is being offered.
    assign out_addr_o     = out_valid_o ? r_addr[r_head] : '0;
    assign out_prot_o     = out_valid_o ? r_ent[r_head].prot : '0;
    assign out_rdata_o    = out_valid_o ? r_rdata[r_head] : '0;
    assign out_err_o      = out_valid_o && r_ent[r_head].err;
    assign out_pmp_err_o  = out_valid_o && r_ent[r_head].pmp_err;
    assign full_o         = w_full;
    assign outstanding_o  = w_occ;
    assign protocol_err_o = r_perr;

endmodule

// File: tb/tb_cv32e40s_rvfi_obi_tracker.sv
// Directed bench for the RVFI OBI tracker.
// DEPTH=2 instance for scenarios, DEPTH=3 for wrap traffic.
module tb_cv32e40s_rvfi_obi_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // DEPTH=2 instance signals
    logic        a_req_v, a_req_pmp, a_resp_v, a_resp_err;
    logic        a_flush, a_rdy;
    logic [31:0] a_req_addr, a_resp_data;
    logic [2:0]  a_req_prot;
    logic        a_ov, a_oerr, a_opmp, a_full, a_perr;
    logic [31:0] a_oaddr, a_odata;
    logic [2:0]  a_oprot;
    logic [1:0]  a_outs;

    // DEPTH=3 instance signals
    logic        b_req_v, b_req_pmp, b_resp_v, b_resp_err;
    logic        b_flush, b_rdy;
    logic [31:0] b_req_addr, b_resp_data;
    logic [2:0]  b_req_prot;
    logic        b_ov, b_oerr, b_opmp, b_full, b_perr;
    logic [31:0] b_oaddr, b_odata;
    logic [2:0]  b_oprot;
    logic [1:0]  b_outs;

    cv32e40s_rvfi_obi_tracker #(.DEPTH(2)) u_d2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (a_req_v),
        .req_addr_i     (a_req_addr),
        .req_prot_i     (a_req_prot),
        .req_pmp_err_i  (a_req_pmp),
        .resp_valid_i   (a_resp_v),
        .resp_rdata_i   (a_resp_data),
        .resp_err_i     (a_resp_err),
        .flush_i        (a_flush),
        .out_valid_o    (a_ov),
        .out_ready_i    (a_rdy),
        .out_addr_o     (a_oaddr),
        .out_prot_o     (a_oprot),
        .out_rdata_o    (a_odata),
        .out_err_o      (a_oerr),
        .out_pmp_err_o  (a_opmp),
        .full_o         (a_full),
        .outstanding_o  (a_outs),
        .protocol_err_o (a_perr)
    );

    cv32e40s_rvfi_obi_tracker #(.DEPTH(3)) u_d3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (b_req_v),
        .req_addr_i     (b_req_addr),
        .req_prot_i     (b_req_prot),
        .req_pmp_err_i  (b_req_pmp),
        .resp_valid_i   (b_resp_v),
        .resp_rdata_i   (b_resp_data),
        .resp_err_i     (b_resp_err),
        .flush_i        (b_flush),
        .out_valid_o    (b_ov),
        .out_ready_i    (b_rdy),
        .out_addr_o     (b_oaddr),
        .out_prot_o     (b_oprot),
        .out_rdata_o    (b_odata),
        .out_err_o      (b_oerr),
        .out_pmp_err_o  (b_opmp),
        .full_o         (b_full),
        .outstanding_o  (b_outs),
        .protocol_err_o (b_perr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req_v = 0; a_req_pmp = 0; a_req_addr = '0;
        a_req_prot = '0; a_resp_v = 0; a_resp_data = '0;
        a_resp_err = 0; a_flush = 0; a_rdy = 1;
        b_req_v = 0; b_req_pmp = 0; b_req_addr = '0;
        b_req_prot = '0; b_resp_v = 0; b_resp_data = '0;
        b_resp_err = 0; b_flush = 0; b_rdy = 1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++;
        if (a_ov !== 1'b0 || a_full !== 1'b0 || a_outs !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status: ov=%b full=%b outs=%0d want 0/0/0",
                     a_ov, a_full, a_outs);
        end
        n_chk++;
        if (a_oaddr !== 32'h0 || a_odata !== 32'h0 || a_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_payload: addr=%h data=%h perr=%b want 0",
                     a_oaddr, a_odata, a_perr);
        end
        n_chk++;
        if (b_ov !== 1'b0 || b_outs !== 2'd0 || b_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_d3: ov=%b outs=%0d full=%b want 0",
                     b_ov, b_outs, b_full);
        end
        // Reset in the middle of a transaction.
        a_req_v = 1; a_req_addr = 32'h40;
        tick();
        a_req_v = 0;
        n_chk++;
        if (a_outs !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_pre_outs: got %0d want 1", a_outs);
        end
        rst_n = 0;
        #2;
        n_chk++;
        if (a_outs !== 2'd0 || a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: outs=%0d ov=%b want 0/0",
                     a_outs, a_ov);
        end
        tick();
        rst_n = 1;
        tick();
        // The late response has no credit left: unexpected.
        a_resp_v = 1; a_resp_data = 32'hDEAD;
        tick();
        a_resp_v = 0;
        n_chk++;
        if (a_perr !== 1'b1 || a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_forget: perr=%b ov=%b want 1/0",
                     a_perr, a_ov);
        end
    endtask

    task automatic test_in_order();
        apply_reset();
        a_req_v = 1; a_req_addr = 32'h100; a_req_prot = 3'd5;
        tick();
        n_chk++;
        if (a_ov !== 1'b0 || a_outs !== 2'd1) begin
            n_fail++;
            $display("FAIL io_alloc_a: ov=%b outs=%0d want 0/1",
                     a_ov, a_outs);
        end
        a_req_addr = 32'h104; a_req_prot = 3'd2;
        tick();
        a_req_v = 0;
        n_chk++;
        if (a_outs !== 2'd2 || a_full !== 1'b1 || a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL io_alloc_b: outs=%0d full=%b ov=%b want 2/1/0",
                     a_outs, a_full, a_ov);
        end
        a_resp_v = 1; a_resp_data = 32'hAAAA;
        tick();
        n_chk++;
        if (a_ov !== 1'b1 || a_oaddr !== 32'h100 ||
            a_odata !== 32'hAAAA || a_oprot !== 3'd5) begin
            n_fail++;
            $display("FAIL io_ret_a: ov=%b addr=%h data=%h prot=%0d want 1/100/aaaa/5",
                     a_ov, a_oaddr, a_odata, a_oprot);
        end
        a_resp_data = 32'hBBBB; a_resp_err = 1;
        tick();
        a_resp_v = 0; a_resp_err = 0;
        n_chk++;
        if (a_ov !== 1'b1 || a_oaddr !== 32'h104 ||
            a_odata !== 32'hBBBB || a_oerr !== 1'b1) begin
            n_fail++;
            $display("FAIL io_ret_b: ov=%b addr=%h data=%h err=%b want 1/104/bbbb/1",
                     a_ov, a_oaddr, a_odata, a_oerr);
        end
        tick();
        n_chk++;
        if (a_ov !== 1'b0 || a_outs !== 2'd0 || a_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL io_drain: ov=%b outs=%0d perr=%b want 0/0/0",
                     a_ov, a_outs, a_perr);
        end
    endtask

    task automatic test_pmp_order();
        apply_reset();
        a_rdy = 0;
        a_req_v = 1; a_req_addr = 32'h200;
        tick();
        a_req_addr = 32'h204; a_req_pmp = 1;
        tick();
        a_req_v = 0; a_req_pmp = 0;
        n_chk++;
        if (a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL pmp_behind: ov=%b want 0", a_ov);
        end
        a_resp_v = 1; a_resp_data = 32'h1234; a_rdy = 1;
        tick();
        a_resp_v = 0;
        n_chk++;
        if (a_ov !== 1'b1 || a_oaddr !== 32'h200 ||
            a_odata !== 32'h1234 || a_opmp !== 1'b0) begin
            n_fail++;
            $display("FAIL pmp_first: ov=%b addr=%h data=%h pmp=%b want 1/200/1234/0",
                     a_ov, a_oaddr, a_odata, a_opmp);
        end
        tick();
        n_chk++;
        if (a_ov !== 1'b1 || a_oaddr !== 32'h204 ||
            a_odata !== 32'h0 || a_opmp !== 1'b1) begin
            n_fail++;
            $display("FAIL pmp_second: ov=%b addr=%h data=%h pmp=%b want 1/204/0/1",
                     a_ov, a_oaddr, a_odata, a_opmp);
        end
        tick();
        n_chk++;
        if (a_ov !== 1'b0 || a_outs !== 2'd0) begin
            n_fail++;
            $display("FAIL pmp_drain: ov=%b outs=%0d want 0/0",
                     a_ov, a_outs);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        a_req_v = 1; a_req_addr = 32'h300;
        tick();
        a_req_addr = 32'h304;
        tick();
        a_req_addr = 32'h308;
        tick();
        a_req_v = 0;
        n_chk++;
        if (a_full !== 1'b1 || a_perr !== 1'b1 || a_outs !== 2'd2) begin
            n_fail++;
            $display("FAIL ovf_status: full=%b perr=%b outs=%0d want 1/1/2",
                     a_full, a_perr, a_outs);
        end
        a_resp_v = 1; a_resp_data = 32'h1;
        tick();
        a_resp_data = 32'h2;
        tick();
        a_resp_v = 0;
        n_chk++;
        if (a_oaddr !== 32'h304 || a_odata !== 32'h2) begin
            n_fail++;
            $display("FAIL ovf_second: addr=%h data=%h want 304/2",
                     a_oaddr, a_odata);
        end
        tick();
        n_chk++;
        if (a_ov !== 1'b0 || a_outs !== 2'd0 || a_perr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_dropped: ov=%b outs=%0d perr=%b want 0/0/1",
                     a_ov, a_outs, a_perr);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        a_req_v = 1; a_req_addr = 32'h400;
        tick();
        a_req_addr = 32'h404;
        tick();
        a_req_v = 0;
        a_flush = 1;
        tick();
        a_flush = 0;
        n_chk++;
        if (a_outs !== 2'd2 || a_full !== 1'b1 || a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_credit: outs=%0d full=%b ov=%b want 2/1/0",
                     a_outs, a_full, a_ov);
        end
        a_resp_v = 1; a_resp_data = 32'h11;
        tick();
        n_chk++;
        if (a_outs !== 2'd1 || a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop1: outs=%0d ov=%b want 1/0",
                     a_outs, a_ov);
        end
        tick();
        a_resp_v = 0;
        n_chk++;
        if (a_outs !== 2'd0 || a_ov !== 1'b0 || a_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop2: outs=%0d ov=%b perr=%b want 0/0/0",
                     a_outs, a_ov, a_perr);
        end
    endtask

    task automatic test_flush_resp();
        apply_reset();
        a_req_v = 1; a_req_addr = 32'h500;
        tick();
        a_req_addr = 32'h504;
        tick();
        a_flush = 1; a_resp_v = 1; a_resp_data = 32'h77;
        a_req_addr = 32'h600; a_req_prot = 3'd3;
        tick();
        a_flush = 0; a_req_v = 0;
        n_chk++;
        if (a_outs !== 2'd2 || a_ov !== 1'b0 || a_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL fr_state: outs=%0d ov=%b perr=%b want 2/0/0",
                     a_outs, a_ov, a_perr);
        end
        a_resp_data = 32'h5555;
        tick();
        n_chk++;
        if (a_outs !== 2'd1 || a_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL fr_drop: outs=%0d ov=%b want 1/0",
                     a_outs, a_ov);
        end
        a_resp_data = 32'h6666;
        tick();
        a_resp_v = 0;
        n_chk++;
        if (a_ov !== 1'b1 || a_oaddr !== 32'h600 ||
            a_odata !== 32'h6666 || a_oprot !== 3'd3) begin
            n_fail++;
            $display("FAIL fr_newreq: ov=%b addr=%h data=%h prot=%0d want 1/600/6666/3",
                     a_ov, a_oaddr, a_odata, a_oprot);
        end
        tick();
        n_chk++;
        if (a_outs !== 2'd0 || a_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL fr_drain: outs=%0d perr=%b want 0/0",
                     a_outs, a_perr);
        end
    endtask

    task automatic test_back_to_back();
        int nreq = 0;
        int nresp = 0;
        int npop = 0;
        int cyc = 0;
        logic want_full;
        apply_reset();
        while (npop < 10 && cyc < 200) begin
            b_rdy = (cyc % 2 == 0);
            want_full = ((nreq - npop) == 3);
            n_chk++;
            if (b_full !== want_full) begin
                n_fail++;
                $display("FAIL b2b_full cyc%0d: got %b want %b",
                         cyc, b_full, want_full);
            end
            if (b_ov && b_rdy) begin
                n_chk++;
                if (b_oaddr !== 32'h1000 + 32'(4 * npop) ||
                    b_odata !== 32'hD000 + 32'(npop)) begin
                    n_fail++;
                    $display("FAIL b2b_ret%0d: addr=%h data=%h want %h/%h",
                             npop, b_oaddr, b_odata,
                             32'h1000 + 32'(4 * npop),
                             32'hD000 + 32'(npop));
                end
                npop++;
            end
            b_resp_v = (nresp < nreq);
            b_resp_data = 32'hD000 + 32'(nresp);
            b_req_v = (nreq < 10) && !want_full;
            b_req_addr = 32'h1000 + 32'(4 * nreq);
            if (b_resp_v) nresp++;
            if (b_req_v) nreq++;
            tick();
            cyc++;
        end
        b_req_v = 0; b_resp_v = 0;
        n_chk++;
        if (npop != 10) begin
            n_fail++;
            $display("FAIL b2b_timeout: retired %0d want 10", npop);
        end
        tick();
        n_chk++;
        if (b_outs !== 2'd0 || b_ov !== 1'b0 || b_perr !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: outs=%0d ov=%b perr=%b want 0/0/0",
                     b_outs, b_ov, b_perr);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_in_order();
        test_pmp_order();
        test_overflow();
        test_flush();
        test_flush_resp();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
